fft_mix_sequencer: RTL and testbench
====================================

# fft_mix_sequencer

Controller for the radix-4 FFT output rotator. It sequences one transform of `STAGE_NUM` passes over four memory banks of `2**ADDR_BIT` words each. For every butterfly result it drives the rotator select, then one cycle later issues the aligned bank write address and write enable. It sits between the butterfly pipeline (valid strobe) and the bank write port, with the output rotator (1-cycle registered) in between.

## Interface
- `ADDR_BIT`, 8, bank address width; words per bank = 2**ADDR_BIT; must be even.
- `STAGE_NUM`, 5, radix-4 passes per transform (N = 4**STAGE_NUM = 4·2**ADDR_BIT).
- `STAGE_BIT`, 3, width of stage index; 2**STAGE_BIT ≥ STAGE_NUM.

Ports:
- `iCLK` in 1: single clock, all state on rising edge.
- `iRESET` in 1: asynchronous, active-high reset.
- `iSTART` in 1: one-cycle start request; honoured only in IDLE.
- `iVALID` in 1: butterfly outputs X0..X3 valid this cycle.
- `oSEL` out 2: rotator select, same cycle as `iVALID`.
- `oWR_EN` out 1: bank write enable, aligned with the rotator's registered output.
- `oWR_ADDR` out ADDR_BIT: bank write address, aligned with `oWR_EN`.
- `oSTAGE` out STAGE_BIT: current pass index.
- `oBUSY` out 1: high in RUN and FLUSH.
- `oDONE` out 1: one-cycle pulse at end of transform.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on `iSTART`; the address counter and the stage counter both clear.
  - RUN: the counter increments on each `iVALID`.
    - On `iVALID` at addr = 2**ADDR_BIT−1: addr wraps to 0 and stage increments.
    - If that stage was STAGE_NUM−1, the next state is FLUSH instead.
  - FLUSH: a single cycle that lets the last rotator word reach the write port; then DONE.
  - DONE: `oDONE`=1 for one cycle, then IDLE.
- `oSEL` = (stage + Σ base-4 digits of addr) mod 4.
  - Digits are addr[2k+1:2k], for k = 0..ADDR_BIT/2−1.
  - Combinational from registered counters only; no input feeds through to it.
  - Outside RUN, `oSEL` = 0.
- `oWR_EN` and `oWR_ADDR` are registered copies of (RUN & `iVALID`) and of the current addr.
- `iVALID` outside RUN is ignored (no count, no write).
- `iSTART` outside IDLE is ignored, including in DONE.
- `iVALID` gaps in RUN: the counters hold, and `oWR_EN` is 0 on the following cycle.
- `oSTAGE` holds its final value (STAGE_NUM−1) through FLUSH and DONE, and clears on the next start.

## Timing
- Reset values: state IDLE; `oSEL`, `oWR_EN`, `oWR_ADDR`, `oSTAGE`, `oBUSY`, `oDONE` all 0.
- Reset mid-transform aborts immediately. A write already scheduled for the next edge is dropped.
- `iSTART` at edge t: `oBUSY`=1 from t+1, and the first `iVALID` is accepted at t+1.
- Write latency: `iVALID` at edge t gives `oWR_EN`/`oWR_ADDR` valid for edge t+1, matching the rotator's 1-cycle register.
- Minimum transform with continuous `iVALID`: STAGE_NUM·2**ADDR_BIT RUN cycles + FLUSH + DONE.
  - The last `oWR_EN` occurs in the FLUSH cycle.
  - `oDONE` follows one cycle later.
- Stage boundary: no bubble. The first word of pass s+1 may be valid the cycle after the last word of pass s.

## Structure
- Shared package `fft_pkg`:
  - FSM state encoding (2-bit enum IDLE=0, RUN=1, FLUSH=2, DONE=3).
  - Default `ADDR_BIT`/`STAGE_NUM`.
  - Digit-sum function `fft_digit_sum_mod4`, so the read-side address generator reuses the same bank mapping.
- One sub-module: `fft_mix_sel_calc`, combinational (addr, stage) → `oSEL`, parameterised on `ADDR_BIT`.
- Top holds the FSM, counters and the alignment registers.

## Test plan
All scenarios use `ADDR_BIT`=2 and `STAGE_NUM`=2.
1. Reset and idle:
   - Assert `iRESET` mid-cycle → all outputs 0 asynchronously.
   - `iVALID` pulses while IDLE → no `oWR_EN`.
2. Full transform with continuous `iVALID`:
   - `oSEL` sequence is 0,1,2,3 then 1,2,3,0.
   - `oWR_ADDR` is 0,1,2,3,0,1,2,3, each one cycle after its `oSEL`.
   - `oDONE` pulses exactly 10 cycles after the `iSTART` edge.
3. `iVALID` gaps:
   - Pattern 1,0,0,1… → counters hold during gaps.
   - `oWR_EN` shows the same pattern delayed 1 cycle.
   - `oSEL` is stable across gaps.
4. `iSTART` asserted during RUN and during DONE → ignored; `oSTAGE`/addr progress unchanged.
5. Assert `iRESET` at stage 1, addr 2:
   - Immediate IDLE, with no pending write emitted.
   - A fresh `iSTART` then completes a clean transform identical to scenario 2.
6. Back-to-back: `iSTART` the cycle after `oDONE` → a new transform begins, with `oSTAGE` restarting at 0.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-4 FFT bank-mapping logic.
//   - fft_state_e        : sequencer FSM encoding (IDLE/RUN/FLUSH/DONE)
//   - FFT_DEF_*          : default transform geometry
//   - fft_digit_sum_mod4 : bank index = (stage + sum of base-4 address digits)
//                          mod 4. The read-side address generator uses it too,
//                          so both sides agree on which bank holds each word.
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  localparam int FFT_DEF_ADDR_BIT  = 8;
  localparam int FFT_DEF_STAGE_NUM = 5;
  localparam int FFT_DEF_STAGE_BIT = 3;

  // Widest bank address the digit-sum helper accepts. Narrower addresses are
  // zero-extended; the extra digits are zero and do not change the sum.
  localparam int FFT_MAX_ADDR_BIT = 32;

  // The accumulator is 2 bits wide, so every addition wraps mod 4 for free.
  function automatic logic [1:0] fft_digit_sum_mod4(
    input logic [FFT_MAX_ADDR_BIT-1:0] addr,
    input logic [1:0]                  stage
  );
    logic [1:0] acc;
    acc = stage;
    for (int k = 0; k < FFT_MAX_ADDR_BIT / 2; k++) begin
      acc = acc + addr[2*k +: 2];
    end
    return acc;
  endfunction

endpackage

// File: rtl/fft_mix_sel_calc.sv
// ---------------------------------------------------------------------------
// fft_mix_sel_calc
// Combinational rotator-select generator.
// Ports:
//   addr_i   [ADDR_BIT]  : registered bank address counter
//   stage_i  [STAGE_BIT] : registered pass counter
//   active_i             : high only while the sequencer is in RUN
//   sel_o    [2]         : (stage + digit sum of addr) mod 4, or 0 when idle
// ---------------------------------------------------------------------------
module fft_mix_sel_calc
  import fft_pkg::*;
#(
  parameter int ADDR_BIT  = FFT_DEF_ADDR_BIT,
  parameter int STAGE_BIT = FFT_DEF_STAGE_BIT
) (
  input  logic [ADDR_BIT-1:0]  addr_i,
  input  logic [STAGE_BIT-1:0] stage_i,
  input  logic                 active_i,
  output logic [1:0]           sel_o
);

  // Only the low two stage bits matter: the stage contributes mod 4.
  always_comb begin
    sel_o = 2'd0;
    if (active_i) begin
      sel_o = fft_digit_sum_mod4(FFT_MAX_ADDR_BIT'(addr_i), 2'(stage_i));
    end
  end

endmodule

// File: rtl/fft_mix_sequencer.sv
// ---------------------------------------------------------------------------
// fft_mix_sequencer
// Sequences one radix-4 transform of STAGE_NUM passes over four banks of
// 2**ADDR_BIT words. For each butterfly result it drives the rotator select
// in the iVALID cycle and, one cycle later, the matching bank write strobe
// and address (lined up with the rotator's output register).
// Ports:
//   iCLK, iRESET  : clock, asynchronous active-high reset
//   iSTART        : start request, honoured only in IDLE
//   iVALID        : butterfly outputs valid this cycle (counted only in RUN)
//   oSEL     [2]  : rotator select, same cycle as iVALID
//   oWR_EN        : bank write enable, one cycle after the accepted iVALID
//   oWR_ADDR [ADDR_BIT]  : bank write address, aligned with oWR_EN
//   oSTAGE   [STAGE_BIT] : current pass index
//   oBUSY         : high in RUN and FLUSH
//   oDONE         : one-cycle pulse at the end of the transform
// ---------------------------------------------------------------------------
module fft_mix_sequencer
  import fft_pkg::*;
#(
  parameter int ADDR_BIT  = FFT_DEF_ADDR_BIT,   // must be even
  parameter int STAGE_NUM = FFT_DEF_STAGE_NUM,
  parameter int STAGE_BIT = FFT_DEF_STAGE_BIT   // 2**STAGE_BIT >= STAGE_NUM
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iSTART,
  input  logic                 iVALID,
  output logic [1:0]           oSEL,
  output logic                 oWR_EN,
  output logic [ADDR_BIT-1:0]  oWR_ADDR,
  output logic [STAGE_BIT-1:0] oSTAGE,
  output logic                 oBUSY,
  output logic                 oDONE
);

  fft_state_e           state_q;
  logic [ADDR_BIT-1:0]  addr_q, addr_d;
  logic [STAGE_BIT-1:0] stage_q, stage_d;
  logic [ADDR_BIT-1:0]  wr_addr_q;
  logic                 wr_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 last_word;
  logic                 last_stage;

  // The address counter wraps to 0 naturally after 2**ADDR_BIT-1.
  always_comb begin
    addr_d     = addr_q + ADDR_BIT'(1);
    stage_d    = stage_q + STAGE_BIT'(1);
    last_word  = (addr_q == {ADDR_BIT{1'b1}});
    last_stage = (stage_q == STAGE_BIT'(STAGE_NUM - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      stage_q   <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle and are raised only where needed,
      // which keeps them single-cycle pulses without per-branch clears.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iSTART) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (iVALID) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            addr_q    <= addr_d;
            if (last_word) begin
              // The final pass keeps its index so oSTAGE reads STAGE_NUM-1
              // through FLUSH and DONE.
              if (last_stage) begin
                state_q <= ST_FLUSH;
              end else begin
                stage_q <= stage_d;
              end
            end
          end
        end
        ST_FLUSH: begin
          // The last rotator word is being written during this cycle.
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  fft_mix_sel_calc #(
    .ADDR_BIT  (ADDR_BIT),
    .STAGE_BIT (STAGE_BIT)
  ) u_sel_calc (
    .addr_i   (addr_q),
    .stage_i  (stage_q),
    .active_i (state_q == ST_RUN),
    .sel_o    (oSEL)
  );

  assign oWR_EN   = wr_en_q;
  assign oWR_ADDR = wr_addr_q;
  assign oSTAGE   = stage_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;

endmodule

// File: tb/tb_fft_mix_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_mix_sequencer
// Directed bench for fft_mix_sequencer with ADDR_BIT=2, STAGE_NUM=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// as well, so each sample reflects the state loaded at that edge.
// ---------------------------------------------------------------------------
module tb_fft_mix_sequencer;

  localparam int ADDR_BIT  = 2;
  localparam int STAGE_NUM = 2;
  localparam int STAGE_BIT = 3;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 valid;
  logic [1:0]           sel;
  logic                 wr_en;
  logic [ADDR_BIT-1:0]  wr_addr;
  logic [STAGE_BIT-1:0] stage;
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Hand-derived expectations for one transform (4 words per pass, 2 passes).
  int exp_sel  [8] = '{0, 1, 2, 3, 1, 2, 3, 0};
  int exp_addr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  // Gap pattern: eight 1s spread over 14 cycles.
  int gap_pat  [14] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1};

  fft_mix_sequencer #(
    .ADDR_BIT  (ADDR_BIT),
    .STAGE_NUM (STAGE_NUM),
    .STAGE_BIT (STAGE_BIT)
  ) dut (
    .iCLK     (clk),
    .iRESET   (rst),
    .iSTART   (start),
    .iVALID   (valid),
    .oSEL     (sel),
    .oWR_EN   (wr_en),
    .oWR_ADDR (wr_addr),
    .oSTAGE   (stage),
    .oBUSY    (busy),
    .oDONE    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sel"},     32'(sel),     0);
    check({tag, " wr_en"},   32'(wr_en),   0);
    check({tag, " wr_addr"}, 32'(wr_addr), 0);
    check({tag, " stage"},   32'(stage),   0);
    check({tag, " busy"},    32'(busy),    0);
    check({tag, " done"},    32'(done),    0);
  endtask

  // One transform with continuous iVALID, starting from IDLE. With noise set,
  // iSTART is held high throughout RUN, FLUSH and DONE and must be ignored.
  task automatic full_transform(input string tag, input bit noise);
    start = 1'b1;
    valid = 1'b0;
    tick();                                   // start edge t
    check({tag, " busy after start"}, 32'(busy), 1);
    check({tag, " stage restart"},    32'(stage), 0);
    start = noise;
    valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s sel[%0d]", tag, i), 32'(sel), 32'(exp_sel[i]));
      tick();                                 // edges t+1 .. t+8
      check($sformatf("%s wr_en[%0d]", tag, i), 32'(wr_en), 1);
      check($sformatf("%s wr_addr[%0d]", tag, i), 32'(wr_addr), 32'(exp_addr[i]));
      check($sformatf("%s done early[%0d]", tag, i), 32'(done), 0);
    end
    valid = 1'b0;
    // FLUSH cycle: last write on the port, still busy, select parked at 0.
    check({tag, " flush busy"},  32'(busy),  1);
    check({tag, " flush sel"},   32'(sel),   0);
    check({tag, " flush stage"}, 32'(stage), 1);
    tick();                                   // edge t+9: DONE, the 10th cycle
    check({tag, " done pulse"},  32'(done),  1);
    check({tag, " done busy"},   32'(busy),  0);
    check({tag, " done wr_en"},  32'(wr_en), 0);
    check({tag, " done stage"},  32'(stage), 1);
    tick();                                   // edge t+10: back in IDLE
    start = 1'b0;
    check({tag, " done width"},  32'(done),  0);
    check({tag, " idle busy"},   32'(busy),  0);
    check({tag, " idle stage"},  32'(stage), 1);
  endtask

  initial begin
    int w;
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    // 1. iVALID while IDLE is ignored.
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      tick();
      check($sformatf("idle valid wr_en[%0d]", i), 32'(wr_en), 0);
      check($sformatf("idle valid busy[%0d]", i), 32'(busy), 0);
    end
    valid = 1'b0;
    tick();

    // 2. Full transform with continuous iVALID.
    full_transform("full", 1'b0);

    // 3. iVALID gaps: counters hold, oWR_EN follows the pattern one cycle late.
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    for (int i = 0; i < 14; i++) begin
      check($sformatf("gap sel[%0d]", i), 32'(sel), 32'(exp_sel[w]));
      valid = gap_pat[i][0];
      tick();
      check($sformatf("gap wr_en[%0d]", i), 32'(wr_en), 32'(gap_pat[i]));
      if (gap_pat[i] == 1) begin
        check($sformatf("gap wr_addr[%0d]", i), 32'(wr_addr), 32'(exp_addr[w]));
        w++;
      end
      check($sformatf("gap stage[%0d]", i), 32'(stage), (w >= 8) ? 1 : 32'(w / 4));
    end
    valid = 1'b0;
    check("gap flush busy", 32'(busy), 1);
    tick();
    check("gap done pulse", 32'(done), 1);
    tick();

    // 4. iSTART during RUN, FLUSH and DONE is ignored.
    full_transform("start noise", 1'b1);

    // 5. Reset at stage 1, addr 2 with a write pending.
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pre-reset sel",   32'(sel),   3);
    check("pre-reset stage", 32'(stage), 1);
    check("pre-reset wr_en", 32'(wr_en), 1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    tick();
    check("reset drop wr_en", 32'(wr_en), 0);
    rst   = 1'b0;
    valid = 1'b0;
    tick();
    full_transform("after reset", 1'b0);

    // 6. Back-to-back: iSTART in the cycle right after oDONE.
    full_transform("back to back", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
